ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
- AHB-Lite slave backed by a word-organised RAM. It sits directly downstream of the testbench AHB interface and driver, and consumes the HSEL/HADDR/HWDATA/HTRANS/HWRITE/HSIZE/HREADY stream.
- Returns HREADYOUT/HRESP/HRDATA.
- Supports byte, halfword and word accesses, a programmable number of wait states, and a two-cycle ERROR response for illegal transfers.

Parameters:
- MEM_DEPTH_WORDS, 1024: number of 32-bit words. Legal byte address range is 0 to MEM_DEPTH_WORDS*4-1, and must not exceed 0xFFFF.
- WAIT_STATES, 0: wait cycles (HREADYOUT=0) inserted in every OKAY data phase. Range 0..7.

Ports:
- HCLK  in  1  bus clock, all logic on rising edge
- HRSTN  in  1  reset, asynchronous, active-high
- HSEL  in  1  slave select
- HADDR  in  16  byte address
- HTRANS  in  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ
- HWRITE  in  1  1=write, 0=read
- HSIZE  in  3  0=byte, 1=halfword, 2=word
- HWDATA  in  32  write data, valid in data phase
- HREADY  in  1  bus-level ready (previous transfer complete)
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR
- HRDATA  out  32  read data

Interface: one clock; reset is asynchronous and active-high. The clock port is HCLK. The reset port is HRSTN, and despite its name it is asserted high.

Behaviour:
- Reset (async assert, sync release): state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, pending-write flag cleared. RAM contents are not reset.
  - Reset mid-transfer aborts the transfer. A pending write is discarded and the RAM is unchanged.
- Address phase accepted on a rising edge when HSEL=1, HREADY=1 and HTRANS[1]=1. The block latches HADDR, HWRITE and HSIZE.
- IDLE/BUSY with HSEL=1 and HREADY=1: zero-wait OKAY, no memory effect.
- Error check at acceptance: the transfer is illegal if any of the following holds:
  - HADDR >= MEM_DEPTH_WORDS*4
  - HSIZE > 2
  - HSIZE=1 and HADDR[0]=1
  - HSIZE=2 and HADDR[1:0]!=0
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0.
    - Legal accept with WAIT_STATES>0: go to WAIT, counter=WAIT_STATES.
    - Legal accept with WAIT_STATES=0: data phase completes in the next cycle.
    - Illegal accept: go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements each cycle; at 1, go to IDLE. The final data-phase cycle is HREADYOUT=1.
  - ERR1: HREADYOUT=0, HRESP=1. Always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1.
    - A new legal or illegal accept on this edge is handled exactly as from IDLE.
    - Otherwise go to IDLE.
- OKAY data-phase latency = 1 + WAIT_STATES cycles. ERROR latency is always 2 cycles. No RAM write occurs on ERROR.
- Pipelined address phases presented while HREADYOUT=0 are ignored because HREADY=0. The address phase presented in the final data-phase cycle is accepted.
- Write: on the edge that ends the data phase (HREADYOUT=1), merge HWDATA into RAM[addr[15:2]] using little-endian byte lanes. Byte n maps to HWDATA[8n+7:8n].
  - Byte access enables lane addr[1:0].
  - Halfword access enables lanes {addr[1],0} and {addr[1],1}.
  - Word access enables all four lanes.
- Read: in the read data phase, HRDATA = RAM[latched addr[15:2]] as the full word, regardless of HSIZE. It is read combinationally from the latched address.
  - Read-after-write to the same word in back-to-back transfers returns the new data.
  - HRDATA=0 in every cycle not belonging to an OKAY read data phase.
- HSEL deasserted mid data phase does not abort the current transfer; the data phase completes normally.

Test Plan:
- Reset:
  - Assert HRSTN=1 mid-WAIT of a write to 0x0010 with WAIT_STATES=2 -> HREADYOUT=1, HRESP=0 and HRDATA=0 immediately.
  - After release, reading 0x0010 returns its pre-reset content.
- Word write then read, WAIT_STATES=0:
  - Write 0x0004 <- 0xDEADBEEF, then NONSEQ read 0x0004 back-to-back -> HRDATA=0xDEADBEEF in the cycle after the read address phase.
  - HREADYOUT stays 1 throughout.
- Byte/halfword merge:
  - Word write 0x0008 <- 0x11223344.
  - Byte write 0x0009 <- HWDATA 0x0000AA00.
  - Halfword write 0x000A <- HWDATA 0x55660000.
  - Word read 0x0008 -> 0x5566AA44.
- Wait states, WAIT_STATES=3:
  - Read 0x0000 -> HREADYOUT low for exactly 3 cycles, then high with valid HRDATA.
  - A pipelined NONSEQ held during the waits is accepted only on the ready cycle.
- Errors:
  - Word access at 0x0002 -> one cycle HREADYOUT=0/HRESP=1, then one cycle HREADYOUT=1/HRESP=1, then OKAY.
  - Write to 0x1000 (MEM_DEPTH_WORDS=1024) -> same two-cycle ERROR; word 0 is unchanged on readback.
  - HSIZE=3 -> same two-cycle ERROR.
- IDLE/BUSY and deselect:
  - HTRANS=IDLE or BUSY, or HSEL=0 with HTRANS=NONSEQ write -> HREADYOUT=1, HRESP=0, RAM unchanged.

Source files
------------

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite signal bundle between one master and the SRAM slave.
// HREADY is the bus-level ready, so it travels with the master side.
interface ahb_sram_slave_if;
   logic        HSEL;
   logic [15:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      input  HREADYOUT, HRESP, HRDATA
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      output HREADYOUT, HRESP, HRDATA
   );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave over a word-organised RAM with byte/halfword/word lanes,
// programmable OKAY wait states and a two-cycle ERROR response.
module ahb_sram_slave #(
   parameter int MEM_DEPTH_WORDS = 1024,
   parameter int WAIT_STATES     = 0
) (
   input logic             HCLK,
   input logic             HRSTN,
   ahb_sram_slave_if.slave bus
);
   localparam int          AW        = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
   localparam logic [16:0] MEM_BYTES = 17'(MEM_DEPTH_WORDS * 4);
   localparam logic [2:0]  WS        = 3'(WAIT_STATES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [2:0]    r_cnt;
   logic          r_dphase;
   logic          r_write;
   logic [3:0]    r_be;
   logic [AW-1:0] r_widx;
   logic [31:0]   r_mem [MEM_DEPTH_WORDS];

   logic w_accept;
   logic w_take;
   logic w_legal;
   logic w_hreadyout;
   logic w_hresp;
   logic w_wr_en;

   function automatic logic [3:0] f_lanes(input logic [2:0] size, input logic [1:0] a);
      case (size)
         3'd0:    f_lanes = 4'b0001 << a;
         3'd1:    f_lanes = a[1] ? 4'b1100 : 4'b0011;
         default: f_lanes = 4'b1111;
      endcase
   endfunction

   function automatic logic f_legal(input logic [15:0] a, input logic [2:0] size);
      logic bad;
      bad = ({1'b0, a} >= MEM_BYTES) || (size > 3'd2) ||
            ((size == 3'd1) && a[0]) || ((size == 3'd2) && (a[1:0] != 2'b00));
      return !bad;
   endfunction

   assign w_accept = bus.HSEL && bus.HREADY && ((bus.HTRANS == 2'b10) || (bus.HTRANS == 2'b11));
   assign w_take   = w_accept && w_hreadyout;
   assign w_legal  = f_legal(bus.HADDR, bus.HSIZE);

   always_ff @(posedge HCLK or posedge HRSTN) begin
      if (HRSTN) begin
         r_state  <= S_IDLE;
         r_cnt    <= 3'd0;
         r_dphase <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_hreadyout) begin
            r_dphase <= w_take && w_legal;
            r_cnt    <= (w_take && w_legal) ? WS : 3'd0;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 3'd1;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_ERR2: begin
            if (w_take)
               w_next = !w_legal ? S_ERR1 : ((WS != 3'd0) ? S_WAIT : S_IDLE);
            else
               w_next = S_IDLE;
         end
         S_WAIT:  if (r_cnt == 3'd1) w_next = S_IDLE;
         S_ERR1:  w_next = S_ERR2;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_hreadyout = 1'b1;
      w_hresp     = 1'b0;
      case (r_state)
         S_WAIT: w_hreadyout = 1'b0;
         S_ERR1: begin
            w_hreadyout = 1'b0;
            w_hresp     = 1'b1;
         end
         S_ERR2:  w_hresp = 1'b1;
         default: ;
      endcase
   end

   // Address-phase attributes are only consumed under r_dphase, so they need no reset.
   always_ff @(posedge HCLK) begin
      if (w_take) begin
         r_widx  <= bus.HADDR[AW+1:2];
         r_be    <= f_lanes(bus.HSIZE, bus.HADDR[1:0]);
         r_write <= bus.HWRITE;
      end
   end

   // A pending OKAY data phase only reaches HREADYOUT=1 in IDLE, which is its final cycle.
   assign w_wr_en = r_dphase && r_write && w_hreadyout;

   always_ff @(posedge HCLK) begin
      if (!HRSTN && w_wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (r_be[i]) r_mem[r_widx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
         end
      end
   end

   assign bus.HREADYOUT = w_hreadyout;
   assign bus.HRESP     = w_hresp;
   assign bus.HRDATA    = (r_dphase && !r_write) ? r_mem[r_widx] : 32'd0;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: three instances (0, 2 and 3 wait states), one active at a time,
// checked every cycle against a transfer-level model plus hand-computed literals.
module tb_ahb_sram_slave;
   localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NS = 2'b10;
   localparam logic [2:0] BYTE = 3'd0, HALF = 3'd1, WORD = 3'd2;

   logic HCLK  = 1'b0;
   logic HRSTN = 1'b1;
   always #5 HCLK = ~HCLK;

   logic        hsel   = 1'b0;
   logic [1:0]  htrans = 2'b00;
   logic [15:0] haddr  = 16'd0;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize  = 3'd0;
   logic [31:0] hwdata = 32'd0;
   logic [1:0]  act    = 2'd0;

   logic [2:0]  rdy_v;
   logic [2:0]  resp_v;
   logic [31:0] rdata_v [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      ahb_sram_slave_if u_if ();
      assign u_if.HSEL   = hsel && (act == 2'(g));
      assign u_if.HADDR  = haddr;
      assign u_if.HTRANS = htrans;
      assign u_if.HWRITE = hwrite;
      assign u_if.HSIZE  = hsize;
      assign u_if.HWDATA = hwdata;
      assign u_if.HREADY = u_if.HREADYOUT;
      assign rdy_v[g]    = u_if.HREADYOUT;
      assign resp_v[g]   = u_if.HRESP;
      assign rdata_v[g]  = u_if.HRDATA;
      ahb_sram_slave #(
         .MEM_DEPTH_WORDS(1024),
         .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
      ) u_dut (
         .HCLK (HCLK),
         .HRSTN(HRSTN),
         .bus  (u_if)
      );
   end

   logic        dut_ready;
   logic        dut_resp;
   logic [31:0] dut_rdata;
   assign dut_ready = rdy_v[act];
   assign dut_resp  = resp_v[act];
   assign dut_rdata = rdata_v[act];

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // Transfer-level model: the data phase in flight is described by how many cycles remain.
   int          m_left = 0;
   bit          m_err  = 1'b0;
   bit          m_wr   = 1'b0;
   bit          m_rdy  = 1'b1;
   logic [15:0] m_addr = 16'd0;
   logic [2:0]  m_size = 3'd0;
   logic [31:0] m_mem   [3][1024];
   bit          m_known [3][1024];

   function automatic int ws_of(input logic [1:0] a);
      return (a == 2'd0) ? 0 : ((a == 2'd1) ? 2 : 3);
   endfunction

   function automatic bit m_illegal(input logic [15:0] a, input logic [2:0] z);
      if (int'(a) >= 1024 * 4) return 1'b1;
      if (z > 3'd2) return 1'b1;
      return (int'(a) % (1 << z)) != 0;
   endfunction

   always @(posedge HCLK or posedge HRSTN) begin
      if (HRSTN) begin
         m_left = 0;
         m_err  = 1'b0;
      end else begin
         m_rdy = (m_left <= 1);
         if (m_left == 1 && !m_err && m_wr) begin
            for (int n = 0; n < 4; n++) begin
               if (n >= int'(m_addr) % 4 && n < int'(m_addr) % 4 + (1 << m_size))
                  m_mem[act][m_addr[11:2]][8*n +: 8] = hwdata[8*n +: 8];
            end
            if (m_size == WORD) m_known[act][m_addr[11:2]] = 1'b1;
         end
         if (m_left > 0) m_left--;
         if (m_rdy && hsel && htrans[1]) begin
            m_addr = haddr;
            m_size = hsize;
            m_wr   = hwrite;
            m_err  = m_illegal(haddr, hsize);
            m_left = m_err ? 2 : 1 + ws_of(act);
         end
      end
   end

   always @(negedge HCLK) begin
      chk("hreadyout", 32'(dut_ready), 32'(m_left <= 1));
      chk("hresp", 32'(dut_resp), 32'(m_err && m_left > 0));
      if (!(m_left > 0 && !m_err && !m_wr))
         chk("hrdata_zero", dut_rdata, 32'd0);
      else if (m_known[act][m_addr[11:2]])
         chk("hrdata", dut_rdata, m_mem[act][m_addr[11:2]]);
   end

   task automatic drv(input logic s, input logic [1:0] t, input logic [15:0] a,
                      input logic w, input logic [2:0] z, input logic [31:0] d);
      hsel = s; htrans = t; haddr = a; hwrite = w; hsize = z; hwdata = d;
   endtask

   task automatic wait_ready(input bit at_neg);
      int n;
      n = 0;
      if (!at_neg) @(negedge HCLK);
      while (!dut_ready && n < 50) begin
         @(negedge HCLK);
         n++;
      end
      if (n >= 50) chk("ready_timeout", 32'(dut_ready), 32'd1);
      @(posedge HCLK);
      #1;
   endtask

   task automatic xf(input logic s, input logic [1:0] t, input logic [15:0] a,
                     input logic w, input logic [2:0] z, input logic [31:0] d);
      drv(s, t, a, w, z, d);
      wait_ready(1'b0);
   endtask

   task automatic count_wait(output int n);
      n = 0;
      @(negedge HCLK);
      while (!dut_ready && n < 50) begin
         n++;
         @(negedge HCLK);
      end
   endtask

   initial begin
      int nw;
      repeat (3) @(posedge HCLK);
      #1;
      chk("rst_ready", 32'(dut_ready), 32'd1);
      chk("rst_resp", 32'(dut_resp), 32'd0);
      chk("rst_rdata", dut_rdata, 32'd0);
      HRSTN = 1'b0;
      @(posedge HCLK);
      #1;

      // Zero wait states: write then back-to-back read
      act = 2'd0;
      xf(1, NS, 16'h0004, 1, WORD, 32'd0);
      drv(1, NS, 16'h0004, 0, WORD, 32'hDEADBEEF);
      @(negedge HCLK);
      chk("wr_ready", 32'(dut_ready), 32'd1);
      wait_ready(1'b1);
      drv(1, IDL, 16'h0000, 0, WORD, 32'd0);
      @(negedge HCLK);
      chk("rd_word", dut_rdata, 32'hDEADBEEF);
      chk("rd_ready", 32'(dut_ready), 32'd1);
      wait_ready(1'b1);

      // Byte and halfword lane merge
      xf(1, NS, 16'h0008, 1, WORD, 32'd0);
      xf(1, NS, 16'h0009, 1, BYTE, 32'h11223344);
      xf(1, NS, 16'h000A, 1, HALF, 32'h0000AA00);
      xf(1, NS, 16'h0008, 0, WORD, 32'h55660000);
      drv(1, IDL, 16'h0000, 0, WORD, 32'd0);
      @(negedge HCLK);
      chk("merge", dut_rdata, 32'h5566AA44);
      wait_ready(1'b1);

      // Errors: misaligned word, out of range write, HSIZE=3 with pipelined read
      xf(1, NS, 16'h0000, 1, WORD, 32'd0);
      xf(1, IDL, 16'h0000, 0, WORD, 32'h0BADF00D);
      xf(1, NS, 16'h0002, 0, WORD, 32'd0);
      drv(1, IDL, 16'h0000, 0, WORD, 32'd0);
      @(negedge HCLK);
      chk("mis_err1", 32'({dut_ready, dut_resp}), 32'h1);
      @(negedge HCLK);
      chk("mis_err2", 32'({dut_ready, dut_resp}), 32'h3);
      @(negedge HCLK);
      chk("mis_after", 32'({dut_ready, dut_resp}), 32'h2);
      wait_ready(1'b1);
      xf(1, NS, 16'h1000, 1, WORD, 32'd0);
      drv(1, IDL, 16'h0000, 0, WORD, 32'hFFFFFFFF);
      @(negedge HCLK);
      chk("oob_err1", 32'({dut_ready, dut_resp}), 32'h1);
      @(negedge HCLK);
      chk("oob_err2", 32'({dut_ready, dut_resp}), 32'h3);
      wait_ready(1'b1);
      xf(1, NS, 16'h0000, 0, WORD, 32'hFFFFFFFF);
      drv(1, IDL, 16'h0000, 0, WORD, 32'd0);
      @(negedge HCLK);
      chk("oob_word0", dut_rdata, 32'h0BADF00D);
      wait_ready(1'b1);
      xf(1, NS, 16'h0004, 0, 3'd3, 32'd0);
      drv(1, NS, 16'h0004, 0, WORD, 32'd0);
      @(negedge HCLK);
      chk("sz3_err1", 32'({dut_ready, dut_resp}), 32'h1);
      @(negedge HCLK);
      chk("sz3_err2", 32'({dut_ready, dut_resp}), 32'h3);
      wait_ready(1'b1);
      drv(1, IDL, 16'h0000, 0, WORD, 32'd0);
      @(negedge HCLK);
      chk("err2_accept_rd", dut_rdata, 32'hDEADBEEF);
      wait_ready(1'b1);

      // IDLE, BUSY and deselected NONSEQ writes leave RAM alone
      xf(1, IDL, 16'h0004, 1, WORD, 32'd0);
      xf(1, BSY, 16'h0004, 1, WORD, 32'h12345678);
      xf(0, NS, 16'h0004, 1, WORD, 32'h12345678);
      xf(0, IDL, 16'h0004, 0, WORD, 32'h12345678);
      xf(1, NS, 16'h0004, 0, WORD, 32'h12345678);
      drv(1, IDL, 16'h0000, 0, WORD, 32'd0);
      @(negedge HCLK);
      chk("idle_busy_desel", dut_rdata, 32'hDEADBEEF);
      wait_ready(1'b1);

      // Three wait states with a pipelined NONSEQ held through the waits
      act = 2'd2;
      xf(1, NS, 16'h0000, 1, WORD, 32'd0);
      xf(1, NS, 16'h0004, 1, WORD, 32'hA5A50F0F);
      xf(1, IDL, 16'h0000, 0, WORD, 32'h3C3CC3C3);
      xf(1, NS, 16'h0000, 0, WORD, 32'd0);
      drv(1, NS, 16'h0004, 0, WORD, 32'd0);
      count_wait(nw);
      chk("ws3_waits", 32'(nw), 32'd3);
      chk("ws3_rd0", dut_rdata, 32'hA5A50F0F);
      @(posedge HCLK);
      #1;
      drv(1, IDL, 16'h0000, 0, WORD, 32'd0);
      count_wait(nw);
      chk("ws3_pipe_waits", 32'(nw), 32'd3);
      chk("ws3_rd4", dut_rdata, 32'h3C3CC3C3);
      @(posedge HCLK);
      #1;

      // Reset in the middle of a two-wait-state write
      act = 2'd1;
      xf(1, NS, 16'h0010, 1, WORD, 32'd0);
      xf(1, IDL, 16'h0000, 0, WORD, 32'hCAFEF00D);
      xf(1, NS, 16'h0010, 1, WORD, 32'd0);
      drv(1, IDL, 16'h0000, 0, WORD, 32'h01234567);
      @(negedge HCLK);
      chk("mid_wait_ready", 32'(dut_ready), 32'd0);
      #1 HRSTN = 1'b1;
      #1;
      chk("rst_mid_ready", 32'(dut_ready), 32'd1);
      chk("rst_mid_resp", 32'(dut_resp), 32'd0);
      chk("rst_mid_rdata", dut_rdata, 32'd0);
      @(posedge HCLK);
      #1 HRSTN = 1'b0;
      xf(1, NS, 16'h0010, 0, WORD, 32'd0);
      drv(1, IDL, 16'h0000, 0, WORD, 32'd0);
      @(negedge HCLK);
      chk("rst_keep", dut_rdata, 32'hCAFEF00D);
      wait_ready(1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule
